sync_fifo_param: RTL

Single-clock, parametrised successor to the dual-clock TX FIFO.
- Configurable data width and depth.
- Exposes used-slot and free-slot counts, plus programmable almost-full and almost-empty flags.
- Sticky overflow and underflow error flags with a clear input.
- Sits between the UART byte assembler and the APB master where both run on the bus clock, so no pointer synchronisation is needed.

---
 rtl/sync_fifo_pkg.sv | 19 +
 rtl/sync_fifo_mem.sv | 49 ++++
 rtl/sync_fifo_param.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and types for the single-clock parametrised FIFO.
package sync_fifo_pkg;

    localparam int unsigned DefAddrBits = 4;
    localparam int unsigned DefPtrW     = DefAddrBits + 1;

    // Occupancy / pointer type for the default configuration.
    typedef logic [DefPtrW-1:0] count_t;

    function automatic int unsigned depth_of(input int unsigned addrbits);
        return 32'd1 << addrbits;
    endfunction

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int unsigned ptr_width_of(input int unsigned addrbits);
        return addrbits + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// WIDTH x DEPTH register-array storage with a synchronous write port.
// SYNC_FIFO_FWFT_EN selects a combinational read port; otherwise the read port is registered.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDRBITS = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [ADDRBITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]    wdata_i,
    input  logic                re_i,
    input  logic [ADDRBITS-1:0] raddr_i,
    output logic [WIDTH-1:0]    rdata_o
);

    localparam int unsigned Depth = depth_of(ADDRBITS);

    logic [WIDTH-1:0] mem_q [Depth];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = ^{rst_i, re_i};

    assign rdata_o = mem_q[raddr_i];
`else
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with used/free counts, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a one-cycle registered read.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDRBITS  = 4,
    parameter int unsigned AFULL_TH  = 14,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                clkf,
    input  logic                reset,
    input  logic [WIDTH-1:0]    wdataf,
    input  logic                wenf,
    input  logic                renf,
    input  logic                err_clr,
    output logic [WIDTH-1:0]    rdataf,
    output logic                eflagf,
    output logic                fflagf,
    output logic                afullf,
    output logic                aemptyf,
    output logic [ADDRBITS:0]   usedlocf,
    output logic [ADDRBITS:0]   emptylocf,
    output logic                ovf_err,
    output logic                udf_err
);

    localparam int unsigned Depth = depth_of(ADDRBITS);
    localparam int unsigned PtrW  = ptr_width_of(ADDRBITS);

    typedef logic [PtrW-1:0] ptr_t;

    localparam ptr_t DepthC    = ptr_t'(Depth);
    localparam ptr_t AfullThC  = ptr_t'(AFULL_TH);
    localparam ptr_t AemptyThC = ptr_t'(AEMPTY_TH);

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    ptr_t             used;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] mem_rdata;

    // Status is purely a function of the registered pointers.
    assign used  = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDRBITS-1:0] == rptr_q[ADDRBITS-1:0]) &&
                   (wptr_q[ADDRBITS] != rptr_q[ADDRBITS]);

    assign wr_acc = wenf && !full;
    assign rd_acc = renf && !empty;

    always_comb begin
        wptr_d = wptr_q + ptr_t'(wr_acc);
        rptr_d = rptr_q + ptr_t'(rd_acc);
    end

    // A new error in the same cycle as err_clr wins.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wenf && full) begin
            ovf_d = 1'b1;
        end
        if (renf && empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clkf) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    sync_fifo_mem #(
        .WIDTH    (WIDTH),
        .ADDRBITS (ADDRBITS)
    ) u_mem (
        .clk_i   (clkf),
        .rst_i   (reset),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[ADDRBITS-1:0]),
        .wdata_i (wdataf),
        .re_i    (rd_acc),
        .raddr_i (rptr_q[ADDRBITS-1:0]),
        .rdata_o (mem_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign rdataf = empty ? '0 : mem_rdata;
`else
    assign rdataf = mem_rdata;
`endif

    assign eflagf    = empty;
    assign fflagf    = full;
    assign afullf    = (used >= AfullThC);
    assign aemptyf   = (used <= AemptyThC);
    assign usedlocf  = used;
    assign emptylocf = DepthC - used;
    assign ovf_err   = ovf_q;
    assign udf_err   = udf_q;

endmodule
